// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and types for the LPC-UART bridge serial blocks
package uart_pkg;
  localparam int UART_DIVISOR    = 286;
  localparam int UART_FRAME_BITS = 10;
  localparam int UART_DATA_BITS  = 8;
  localparam int UART_DIV_W      = 9;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: first-word-fall-through byte FIFO feeding the transmitter
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0]  mem_q [DEPTH];
  logic [7:0]  mem_d [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic        do_push, do_pop;
  assign empty = wr_q == rd_q;
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout  = mem_q[rd_q[AW-1:0]];
  // pointer advance and storage write; overflow and underflow requests are dropped
  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    wr_d    = wr_q + {{AW{1'b0}}, do_push};
    rd_d    = rd_q + {{AW{1'b0}}, do_pop};
    mem_d   = mem_q;
    if (do_push) mem_d[wr_q[AW-1:0]] = din;
  end
  // storage and pointers, flushed on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with a valid/ready byte FIFO front end
module uart_tx
  import uart_pkg::*;
#(
  parameter int DIVISOR    = UART_DIVISOR,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       tx,
  output logic       busy
);
  localparam logic [UART_DIV_W-1:0] DIV_MAX  = UART_DIV_W'(DIVISOR);
  localparam logic [2:0]            LAST_BIT = 3'(UART_DATA_BITS - 1);
  tx_state_t             state_q, state_d;
  logic [UART_DIV_W-1:0] div_q, div_d;
  logic [2:0]            bit_q, bit_d;
  logic [7:0]            shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  rdy_q, rdy_d;
  logic                  tc, push, pop;
  logic [7:0]            fifo_dout;
  logic                  fifo_full, fifo_empty;
  assign data_ready = rdy_q && !fifo_full;
  assign push       = data_valid && data_ready;
  assign tx         = tx_q;
  assign busy       = busy_q;
  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
  // frame sequencing: start, eight data bits LSB first, stop, chaining straight into the next start
  always_comb begin
    state_d = state_q;
    div_d   = '0;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    rdy_d   = 1'b1;
    tc      = div_q == DIV_MAX;
    if (state_q != IDLE) div_d = tc ? '0 : div_q + UART_DIV_W'(1);
    case (state_q)
      IDLE: begin
        tx_d = fifo_empty;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          state_d = START;
        end
      end
      START: if (tc) begin
        bit_d   = '0;
        tx_d    = shift_q[0];
        state_d = DATA;
      end
      DATA: if (tc) begin
        if (bit_q == LAST_BIT) begin
          tx_d    = 1'b1;
          state_d = STOP;
        end else begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          tx_d    = shift_q[1];
        end
      end
      STOP: if (tc) begin
        state_d = fifo_empty ? IDLE : START;
        tx_d    = fifo_empty;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE) || !fifo_empty || push;
  end
  // sequencer registers; reset idles the line high and withholds ready until the first clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed checks of the UART transmitter at a short and the nominal bit period
module tb_uart_tx;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] f_data = '0, s_data = '0;
  logic       f_valid = 1'b0, s_valid = 1'b0;
  logic       f_ready, f_tx, f_busy, s_ready, s_tx, s_busy;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  uart_tx #(.DIVISOR(3), .FIFO_DEPTH(4)) u_fast (
    .clk(clk), .rst(rst), .data(f_data), .data_valid(f_valid),
    .data_ready(f_ready), .tx(f_tx), .busy(f_busy)
  );
  uart_tx #(.DIVISOR(286), .FIFO_DEPTH(4)) u_slow (
    .clk(clk), .rst(rst), .data(s_data), .data_valid(s_valid),
    .data_ready(s_ready), .tx(s_tx), .busy(s_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] expand(input logic [7:0] b);
    logic [9:0]  fr;
    logic [39:0] e;
    fr = {1'b1, b, 1'b0};
    for (int i = 0; i < 40; i++) e[i] = fr[i / 4];
    return e;
  endfunction

  task automatic send(input string tag, input logic [7:0] b);
    f_data  = b;
    f_valid = 1'b1;
    step();
    f_valid = 1'b0;
    chk({tag, "_accept_tx"}, 64'(f_tx), 64'd1);
    step();
    chk({tag, "_fall"}, 64'(f_tx), 64'd0);
  endtask

  task automatic frame_check(input string tag, input logic [7:0] b, input logic chain, input logic [7:0] nxt);
    logic [39:0] w;
    logic        all_busy;
    all_busy = 1'b1;
    for (int k = 0; k < 40; k++) begin
      w[k] = f_tx;
      all_busy &= f_busy;
      if (chain && k == 39) begin
        f_data  = nxt;
        f_valid = 1'b1;
      end
      step();
      f_valid = 1'b0;
    end
    chk({tag, "_wave"}, 64'(w), 64'(expand(b)));
    chk({tag, "_busy"}, 64'(all_busy), 64'd1);
  endtask

  task automatic rx_byte(input int elapsed, output logic [9:0] fr);
    logic got;
    got = elapsed != 0;
    for (int i = 0; i < 1000 && !got; i++) begin
      step();
      if (!s_tx) got = 1'b1;
    end
    chk("rx_fall", 64'(got), 64'd1);
    repeat (143 - elapsed) step();
    for (int j = 0; j < 10; j++) begin
      fr[j] = s_tx;
      if (j < 9) repeat (287) step();
    end
  endtask

  initial begin
    logic [279:0] wave;
    logic [9:0]   fr;
    logic         acc, seen_full, started, any_low, any_busy;
    int           idx, n;

    // reset state while rst is held
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx", 64'(f_tx), 64'd1);
    chk("rst_busy", 64'(f_busy), 64'd0);
    chk("rst_ready", 64'(f_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("post_rst_ready", 64'(f_ready), 64'd1);
    chk("post_rst_tx", 64'(f_tx), 64'd1);

    // single 0xA5 frame, busy drops exactly 40 clocks after the fall
    send("a5", 8'hA5);
    frame_check("a5", 8'hA5, 1'b0, 8'h00);
    chk("a5_busy_end", 64'(f_busy), 64'd0);
    chk("a5_tx_end", 64'(f_tx), 64'd1);

    // six bytes offered continuously into a four-entry FIFO
    idx = 1; n = 0; seen_full = 0; started = 0;
    f_data = 8'h01; f_valid = 1'b1;
    for (int c = 0; c < 300; c++) begin
      acc = f_valid && f_ready;
      step();
      if (acc) begin
        idx++;
        if (idx > 6) f_valid = 1'b0;
        else f_data = 8'(idx);
      end
      if (!f_ready) seen_full = 1'b1;
      if (!started && !f_tx) started = 1'b1;
      if (started && n < 280) begin
        wave[n] = f_tx;
        n++;
      end
    end
    chk("burst_accepted", 64'(idx), 64'd7);
    chk("burst_ready_dropped", 64'(seen_full), 64'd1);
    for (int i = 0; i < 6; i++)
      chk($sformatf("burst_frame%0d", i), 64'(wave[40*i +: 40]), 64'(expand(8'(i + 1))));
    chk("burst_tail_idle", 64'(wave[279:240]), 64'hFF_FFFF_FFFF);
    chk("burst_busy_end", 64'(f_busy), 64'd0);

    // reset during data bit 3 of 0x55 with two more bytes queued
    f_data = 8'h55; f_valid = 1'b1;
    step();
    f_data = 8'h11;
    step();
    f_data = 8'h22;
    step();
    f_valid = 1'b0;
    repeat (16) step();
    chk("mid_bit3", 64'(f_tx), 64'd0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_tx", 64'(f_tx), 64'd1);
    chk("mid_rst_busy", 64'(f_busy), 64'd0);
    chk("mid_rst_ready", 64'(f_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("mid_post_ready", 64'(f_ready), 64'd1);
    any_low = 0; any_busy = 0;
    for (int c = 0; c < 100; c++) begin
      any_low |= !f_tx;
      any_busy |= f_busy;
      step();
    end
    chk("mid_no_frames", 64'(any_low), 64'd0);
    chk("mid_no_busy", 64'(any_busy), 64'd0);
    send("3c", 8'h3C);
    frame_check("3c", 8'h3C, 1'b0, 8'h00);
    chk("3c_busy_end", 64'(f_busy), 64'd0);

    // push lands on the last stop clock with the FIFO empty
    send("c3", 8'hC3);
    frame_check("c3", 8'hC3, 1'b1, 8'h96);
    chk("edge_busy", 64'(f_busy), 64'd1);
    chk("edge_tx_idle", 64'(f_tx), 64'd1);
    step();
    chk("edge_fall", 64'(f_tx), 64'd0);
    frame_check("96", 8'h96, 1'b0, 8'h00);
    chk("96_busy_end", 64'(f_busy), 64'd0);

    // nominal bit period, mid-bit sampling as a receiver would
    s_data = 8'h00; s_valid = 1'b1;
    step();
    s_data = 8'hFF;
    step();
    s_data = 8'h7A;
    step();
    s_valid = 1'b0;
    rx_byte(1, fr);
    chk("rx_00", 64'(fr), 64'({1'b1, 8'h00, 1'b0}));
    rx_byte(0, fr);
    chk("rx_ff", 64'(fr), 64'({1'b1, 8'hFF, 1'b0}));
    rx_byte(0, fr);
    chk("rx_7a", 64'(fr), 64'({1'b1, 8'h7A, 1'b0}));
    repeat (300) step();
    chk("rx_busy_end", 64'(s_busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
